// File: rtl/ltssm_detect.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | ltssm_detect: PCIe LTSSM Detect sub-machine (quiet, two-try rx-detect) |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
module ltssm_detect #(
  parameter int WIDTH        = 4,
  parameter int QUIET_CYCLES = 1000,
  parameter int RETRY_CYCLES = 1000,
  parameter int ACK_TIMEOUT  = 64,
  parameter int DET_TIMEOUT  = 4000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_ei_exit,
  output logic             o_rx_det_req,
  input  logic             i_rx_det_ack,
  input  logic             i_rx_det_vld,
  input  logic [WIDTH-1:0] i_rx_present,
  output logic             o_detect_done,
  output logic [WIDTH-1:0] o_lanes_det,
  output logic             o_det_err,
  output logic [2:0]       o_state
);

  localparam int c_MAX_QR  = (QUIET_CYCLES > RETRY_CYCLES) ? QUIET_CYCLES : RETRY_CYCLES;
  localparam int c_MAX_AD  = (ACK_TIMEOUT > DET_TIMEOUT) ? ACK_TIMEOUT : DET_TIMEOUT;
  localparam int c_CNT_MAX = (c_MAX_QR > c_MAX_AD) ? c_MAX_QR : c_MAX_AD;
  localparam int c_CW      = $clog2(c_CNT_MAX + 1);

  localparam logic [c_CW-1:0] c_QUIET_LAST = c_CW'(QUIET_CYCLES - 1);
  localparam logic [c_CW-1:0] c_RETRY_LAST = c_CW'(RETRY_CYCLES - 1);
  localparam logic [c_CW-1:0] c_ACK_LAST   = c_CW'(ACK_TIMEOUT - 1);
  localparam logic [c_CW-1:0] c_DET_LAST   = c_CW'(DET_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_QUIET    = 3'd1,
    S_ACT_REQ  = 3'd2,
    S_ACT_WAIT = 3'd3,
    S_RETRY    = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  state_t            r_state, w_nxt;
  logic [c_CW-1:0]   r_cnt, w_cnt_nxt;
  logic              r_attempt, w_att_nxt;
  logic [WIDTH-1:0]  r_first_mask, w_first_nxt;
  logic [WIDTH-1:0]  r_lanes, w_lanes_nxt;
  logic              r_req, r_err, w_err;
  logic              r_ack_d;
  logic              w_ack_fall;

  assign w_ack_fall = r_ack_d & ~i_rx_det_ack;

  always_comb begin
    w_nxt       = r_state;
    w_err       = 1'b0;
    w_att_nxt   = r_attempt;
    w_first_nxt = r_first_mask;
    w_lanes_nxt = r_lanes;
    if (!i_start) begin
      w_nxt       = S_IDLE;
      w_att_nxt   = 1'b0;
      w_first_nxt = '0;
      w_lanes_nxt = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_nxt     = S_QUIET;
          w_att_nxt = 1'b0;
        end
        S_QUIET: begin
          if ((|i_ei_exit) || (r_cnt == c_QUIET_LAST)) w_nxt = S_ACT_REQ;
        end
        S_ACT_REQ: begin
          if (i_rx_det_ack) begin
            w_nxt = S_ACT_WAIT;
          end else if (r_cnt == c_ACK_LAST) begin
            w_err     = 1'b1;
            w_nxt     = S_QUIET;
            w_att_nxt = 1'b0;
          end
        end
        S_ACT_WAIT: begin
          if (w_ack_fall && i_rx_det_vld) begin
            if (!r_attempt) begin
              if (&i_rx_present) begin
                w_lanes_nxt = i_rx_present;
                w_nxt       = S_DONE;
              end else if (~|i_rx_present) begin
                w_nxt = S_QUIET;
              end else begin
                // Partial result: remember it and confirm with a second attempt.
                w_first_nxt = i_rx_present;
                w_att_nxt   = 1'b1;
                w_nxt       = S_RETRY;
              end
            end else if (i_rx_present == r_first_mask) begin
              w_lanes_nxt = r_first_mask;
              w_nxt       = S_DONE;
            end else begin
              w_nxt     = S_QUIET;
              w_att_nxt = 1'b0;
            end
          end else if (w_ack_fall || (r_cnt == c_DET_LAST)) begin
            w_err     = 1'b1;
            w_nxt     = S_QUIET;
            w_att_nxt = 1'b0;
          end
        end
        S_RETRY: begin
          if (r_cnt == c_RETRY_LAST) w_nxt = S_ACT_REQ;
        end
        S_DONE: begin
          w_nxt = S_DONE;
        end
        default: begin
          w_nxt = S_IDLE;
        end
      endcase
    end
  end

  // Counter restarts on every state entry and idles at zero where nothing is timed.
  always_comb begin
    w_cnt_nxt = r_cnt + 1'b1;
    if ((w_nxt != r_state) || (r_state == S_IDLE) || (r_state == S_DONE)) w_cnt_nxt = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_attempt    <= 1'b0;
      r_first_mask <= '0;
      r_lanes      <= '0;
      r_req        <= 1'b0;
      r_err        <= 1'b0;
      r_ack_d      <= 1'b0;
    end else begin
      r_state      <= w_nxt;
      r_cnt        <= w_cnt_nxt;
      r_attempt    <= w_att_nxt;
      r_first_mask <= w_first_nxt;
      r_lanes      <= w_lanes_nxt;
      r_req        <= (w_nxt == S_ACT_REQ);
      r_err        <= w_err;
      r_ack_d      <= i_rx_det_ack;
    end
  end

  assign o_rx_det_req  = r_req;
  assign o_detect_done = (r_state == S_DONE);
  assign o_lanes_det   = r_lanes;
  assign o_det_err     = r_err;
  assign o_state       = r_state;

endmodule
`default_nettype wire

// File: tb/tb_ltssm_detect.sv
`default_nettype none
`timescale 1ns/1ps
// Bench for ltssm_detect: table of detect scenarios plus hand-written corner sequences.
module tb_ltssm_detect;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       ack = 1'b0;
  logic       vld = 1'b0;
  logic [3:0] ei = 4'h0;
  logic [3:0] present = 4'h0;
  logic       req, done, err;
  logic [3:0] lanes;
  logic [2:0] st;

  always #5 clk = ~clk;

  ltssm_detect #(
    .WIDTH(4), .QUIET_CYCLES(1000), .RETRY_CYCLES(1000),
    .ACK_TIMEOUT(64), .DET_TIMEOUT(4000)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_start(start), .i_ei_exit(ei),
    .o_rx_det_req(req), .i_rx_det_ack(ack), .i_rx_det_vld(vld),
    .i_rx_present(present), .o_detect_done(done), .o_lanes_det(lanes),
    .o_det_err(err), .o_state(st)
  );

  typedef struct {
    logic [3:0] p1;
    logic       v1;
    logic [3:0] p2;
    logic [2:0] st;
    logic [3:0] lanes;
    logic       err;
  } vec_t;

  typedef struct {
    logic [2:0] st;
    logic [3:0] lanes;
    logic       err;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic wait_req(input int budget, output int n);
    n = 0;
    while (req !== 1'b1 && n < budget) begin
      step();
      n++;
    end
    if (req !== 1'b1) chk("req_wait_expired", {31'b0, req}, 32'd1);
  endtask

  // Receiver-detect circuit model: ack for two cycles, then drop ack with the result.
  task automatic handshake(input logic [3:0] p, input logic v);
    ack = 1'b1;
    step();
    chk("req_drop_on_ack", {31'b0, req}, 32'd0);
    chk("enter_act_wait", {29'b0, st}, 32'd3);
    step();
    ack = 1'b0;
    vld = v;
    present = p;
    step();
    vld = 1'b0;
    present = 4'h0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t tbl[6];
    exp_t e;
    int   n;

    tbl[0] = '{4'hF, 1'b1, 4'h0, 3'd5, 4'hF, 1'b0};
    tbl[1] = '{4'h3, 1'b1, 4'h3, 3'd5, 4'h3, 1'b0};
    tbl[2] = '{4'h3, 1'b1, 4'h1, 3'd1, 4'h0, 1'b0};
    tbl[3] = '{4'h0, 1'b1, 4'h0, 3'd1, 4'h0, 1'b0};
    tbl[4] = '{4'h5, 1'b1, 4'h5, 3'd5, 4'h5, 1'b0};
    tbl[5] = '{4'hF, 1'b0, 4'h0, 3'd1, 4'h0, 1'b1};

    step();
    chk("rst_state", {29'b0, st}, 32'd0);
    chk("rst_req", {31'b0, req}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_lanes", {28'b0, lanes}, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 6; i++) begin
      start = 1'b0;
      step();
      step();
      chk("idle_state", {29'b0, st}, 32'd0);
      sb.push_back('{tbl[i].st, tbl[i].lanes, tbl[i].err});
      start = 1'b1;
      wait_req(1100, n);
      chk("quiet_len", n, 32'd1001);
      handshake(tbl[i].p1, tbl[i].v1);
      if (tbl[i].v1 && tbl[i].p1 != 4'h0 && tbl[i].p1 != 4'hF) begin
        chk("enter_retry", {29'b0, st}, 32'd4);
        chk("retry_no_err", {31'b0, err}, 32'd0);
        wait_req(1100, n);
        chk("retry_len", n, 32'd1000);
        handshake(tbl[i].p2, 1'b1);
      end
      e = sb.pop_front();
      chk("result_state", {29'b0, st}, {29'b0, e.st});
      chk("result_lanes", {28'b0, lanes}, {28'b0, e.lanes});
      chk("result_err", {31'b0, err}, {31'b0, e.err});
      chk("result_done", {31'b0, done}, {31'b0, (e.st == 3'd5)});
      step();
      chk("err_single_pulse", {31'b0, err}, 32'd0);
      chk("lanes_held", {28'b0, lanes}, {28'b0, e.lanes});
    end

    // Electrical-idle exit at QUIET cycle 50 cuts the quiet period short.
    start = 1'b0;
    step();
    start = 1'b1;
    step();
    chk("ei_in_quiet", {29'b0, st}, 32'd1);
    repeat (50) step();
    ei = 4'b0010;
    step();
    ei = 4'b0000;
    chk("ei_act_req", {29'b0, st}, 32'd2);
    chk("ei_req", {31'b0, req}, 32'd1);
    handshake(4'hF, 1'b1);
    chk("ei_done", {29'b0, st}, 32'd5);
    ei = 4'hF;
    step();
    chk("ei_ignored_in_done", {29'b0, st}, 32'd5);
    ei = 4'h0;

    // Ack never arrives: single det_err pulse, back to QUIET, full retry loop.
    start = 1'b0;
    step();
    start = 1'b1;
    wait_req(1100, n);
    n = 0;
    while (err !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    chk("ack_timeout_len", n, 32'd64);
    chk("ack_timeout_state", {29'b0, st}, 32'd1);
    chk("ack_timeout_req", {31'b0, req}, 32'd0);
    step();
    chk("ack_timeout_pulse", {31'b0, err}, 32'd0);
    wait_req(1100, n);
    chk("requiet_len", n, 32'd999);
    handshake(4'hF, 1'b1);
    chk("timeout_recover_done", {31'b0, done}, 32'd1);
    chk("timeout_recover_lanes", {28'b0, lanes}, 32'hF);

    // start=0 in DONE clears everything within one cycle.
    start = 1'b0;
    step();
    chk("stop_state", {29'b0, st}, 32'd0);
    chk("stop_done", {31'b0, done}, 32'd0);
    chk("stop_lanes", {28'b0, lanes}, 32'd0);
    chk("stop_req", {31'b0, req}, 32'd0);
    chk("stop_err", {31'b0, err}, 32'd0);

    // Reset mid-handshake, then stale ack/vld must not complete a detect.
    start = 1'b1;
    wait_req(1100, n);
    ack = 1'b1;
    step();
    chk("pre_rst_act_wait", {29'b0, st}, 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_state", {29'b0, st}, 32'd0);
    chk("async_rst_req", {31'b0, req}, 32'd0);
    chk("async_rst_done", {31'b0, done}, 32'd0);
    step();
    rst_n = 1'b1;
    vld = 1'b1;
    present = 4'hF;
    step();
    step();
    ack = 1'b0;
    step();
    step();
    chk("stale_ack_state", {29'b0, st}, 32'd1);
    chk("stale_ack_done", {31'b0, done}, 32'd0);
    chk("stale_ack_err", {31'b0, err}, 32'd0);
    vld = 1'b0;
    present = 4'h0;
    wait_req(1100, n);
    handshake(4'hF, 1'b1);
    chk("post_rst_done", {29'b0, st}, 32'd5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ltssm_detect.md
LTSSM_DETECT -- requirements
Module: ltssm_detect

Interface
REQ-001 Parameters: WIDTH, 4, lane count; QUIET_CYCLES, 1000, Detect.Quiet timeout in clk cycles; RETRY_CYCLES, 1000, wait before second detect attempt; ACK_TIMEOUT, 64, max cycles req-to-ack; DET_TIMEOUT, 4000, max cycles ack-rise-to-ack-fall.
REQ-002 clk  input  1  single clock, all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous assert, active-low (0 = reset), synchronous deassert assumed by top.
REQ-004 start  input  1  level enable from LTSSM top; 1 = run detect, 0 = return to IDLE.
REQ-005 ei_exit  input  WIDTH  per-lane electrical-idle-exit indication from the elec_idle model.
REQ-006 rx_det_req  output  1  receiver-detect request to the rx_det_circuit model.
REQ-007 rx_det_ack  input  1  detect-in-progress from rx_det_circuit; high during detection.
REQ-008 rx_det_vld  input  1  detect-result-valid from rx_det_circuit.
REQ-009 rx_present  input  WIDTH  per-lane receiver-present result, sampled at detect completion.
REQ-010 detect_done  output  1  level, high only in DONE.
REQ-011 lanes_det  output  WIDTH  lanes with receiver confirmed; valid while detect_done=1.
REQ-012 det_err  output  1  one-cycle pulse on handshake timeout.
REQ-013 state  output  3  current state encoding: IDLE=0, QUIET=1, ACT_REQ=2, ACT_WAIT=3, RETRY=4, DONE=5.

Function
REQ-014 IDLE: start=1 -> QUIET next cycle, cycle counter cleared, attempt flag cleared.
REQ-015 QUIET: counter increments each cycle; exit to ACT_REQ when counter reaches QUIET_CYCLES-1 or any ei_exit bit is 1, whichever first.
REQ-016 ACT_REQ: rx_det_req=1 (registered); on first cycle rx_det_ack=1 -> ACT_WAIT with rx_det_req=0 from that edge; ACK_TIMEOUT cycles without ack -> det_err pulse, QUIET.
REQ-017 rx_det_req SHALL be 0 for at least one cycle between consecutive ACT_REQ entries so every request presents a rising edge.
REQ-018 ACT_WAIT: completion = ack falling edge (ack 1 in previous cycle, 0 now) with rx_det_vld=1; rx_present sampled in that cycle into result register.
REQ-019 ACT_WAIT: ack falling with rx_det_vld=0, or DET_TIMEOUT cycles without ack fall -> result treated as all-zero, det_err pulse, QUIET.
REQ-020 First attempt result: all ones -> lanes_det=result, DONE; all zeros -> QUIET; partial -> store result in first_mask, set attempt flag, RETRY.
REQ-021 RETRY: wait RETRY_CYCLES cycles -> ACT_REQ (second attempt).
REQ-022 Second attempt result: equal to first_mask -> lanes_det=first_mask, DONE; else QUIET, attempt flag cleared.
REQ-023 DONE: detect_done=1, lanes_det held; stays until start=0.
REQ-024 start=0 in any state -> IDLE next cycle, rx_det_req=0, counters and attempt flag cleared, lanes_det=0; start has priority over all other transitions.
REQ-025 ei_exit ignored outside QUIET; ack/vld ignored outside ACT_REQ/ACT_WAIT.
REQ-026 Counters sized to hold max(QUIET_CYCLES, RETRY_CYCLES, DET_TIMEOUT) without wrap; cleared on every state entry.
REQ-027 det_err and a state transition occur in the same cycle; det_err never high for two consecutive cycles.

Reset
REQ-028 rst=0 immediately forces: state=IDLE, rx_det_req=0, detect_done=0, lanes_det=0, det_err=0, counters=0, attempt flag=0, first_mask=0.
REQ-029 rst=0 mid-handshake abandons detection; after release the block does not act on stale ack/vld until next ACT_REQ.

Verification
REQ-030 WIDTH=4, start=1, ei_exit=0, model rx_present=4'hF -> QUIET for 1000 cycles, one req pulse, ack fall -> DONE, lanes_det=4'hF.
REQ-031 ei_exit=4'b0010 at cycle 50 of QUIET -> ACT_REQ on cycle 51, not after 1000.
REQ-032 rx_present=4'b0011 on both attempts -> RETRY 1000 cycles, second req, DONE with lanes_det=4'b0011; changed to 4'b0001 on second -> QUIET.
REQ-033 ack held 0 -> det_err single pulse at ACK_TIMEOUT=64, state=QUIET, then full retry loop.
REQ-034 rst=0 during ACT_WAIT, and separately start=0 in DONE -> all outputs 0, state=IDLE within one cycle (reset: immediately).
